// File: rtl/freelist_alloc_ctrl_pkg.sv
// Shared definitions for the freelist allocation controller: sizing constants,
// ROB recovery-state encodings, controller FSM states and a small popcount helper.
package freelist_alloc_ctrl_pkg;

  localparam int NUM_REGS       = 32;
  localparam int LOG_NUM_REGS   = 5;
  localparam int PREG_IDX_WIDTH = 6;
  localparam int WALK_SIZE      = 2;

  // Encodings of the rob_state input.
  localparam logic [1:0] ROB_STATE_IDLE     = 2'd0;
  localparam logic [1:0] ROB_STATE_ROLLBACK = 2'd1;
  localparam logic [1:0] ROB_STATE_WALK     = 2'd2;

  typedef enum logic [2:0] {
    CTRL_INIT     = 3'd0,
    CTRL_IDLE     = 3'd1,
    CTRL_ROLLBACK = 3'd2,
    CTRL_WALK     = 3'd3,
    CTRL_RESUME   = 3'd4
  } ctrl_state_e;

  // Number of set bits in a two-lane vector (0..2).
  function automatic logic [1:0] popcnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/freelist_lane_steer.sv
// Combinational lane steering: counts lanes needing a preg, compacts their
// requests onto freelist deq ports 0/1 and routes the returned pregs back.
module freelist_lane_steer
  import freelist_alloc_ctrl_pkg::*;
(
  input  logic                      ren0_valid,
  input  logic                      ren0_need,
  input  logic                      ren1_valid,
  input  logic                      ren1_need,
  input  logic                      fire,
  input  logic [PREG_IDX_WIDTH-1:0] fl_data0,
  input  logic [PREG_IDX_WIDTH-1:0] fl_data1,
  output logic [1:0]                need,
  output logic                      fl_req0_valid,
  output logic                      fl_req1_valid,
  output logic [PREG_IDX_WIDTH-1:0] ren0_pdst,
  output logic [PREG_IDX_WIDTH-1:0] ren1_pdst
);

  logic lane0_need;
  logic lane1_need;

  // Request compaction and preg return steering.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    ren0_pdst     = '0;
    ren1_pdst     = '0;
    lane0_need    = ren0_valid & ren0_need;
    lane1_need    = ren1_valid & ren1_need;
    need          = popcnt2(lane0_need, lane1_need);
    fl_req0_valid = fire & (need != 2'd0);
    fl_req1_valid = fire & (need == 2'd2);
    if (fire) begin
      if (lane0_need) ren0_pdst = fl_data0;
      // A lone lane1 request is compacted onto port 0.
      if (lane1_need) ren1_pdst = lane0_need ? fl_data1 : fl_data0;
    end
  end

endmodule

// File: rtl/freelist_alloc_ctrl.sv
// Allocation controller in front of the physical-register freelist.
// Gates rename on a free-register credit count, tracks in-flight pregs and
// sequences rename blocking through ROB rollback/walk recovery.
// Optional perf counters are built when FREELIST_CTRL_PERF_EN is defined.
module freelist_alloc_ctrl
  import freelist_alloc_ctrl_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ren0_valid,
  input  logic                      ren0_need,
  input  logic                      ren1_valid,
  input  logic                      ren1_need,
  output logic                      ren_ready,
  output logic [PREG_IDX_WIDTH-1:0] ren0_pdst,
  output logic [PREG_IDX_WIDTH-1:0] ren1_pdst,
  output logic                      fl_req0_valid,
  output logic                      fl_req1_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_data0,
  input  logic [PREG_IDX_WIDTH-1:0] fl_data1,
  input  logic                      free0_valid,
  input  logic                      free1_valid,
  input  logic [1:0]                rob_state,
  input  logic                      rob_walk0_valid,
  input  logic                      rob_walk1_valid,
  output logic [LOG_NUM_REGS:0]     free_count,
  output logic [2:0]                ctrl_state
`ifdef FREELIST_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_stall_cyc,
  output logic [31:0]               perf_alloc_cnt,
  output logic                      perf_err
`endif
);

  ctrl_state_e           state_q, state_d;
  logic [LOG_NUM_REGS:0] free_count_q, free_count_d;
  logic [LOG_NUM_REGS:0] inflight_q, inflight_d;
  logic [1:0]            need;
  logic [1:0]            nfree, nwalk, nalloc;
  logic                  fire;
  logic                  sat;
  int                    fc_i;
  int                    if_i;

  // Credit gate: registered count only, so same-cycle frees never bypass.
  always_comb begin
    ren_ready = (state_q == CTRL_IDLE) &&
                (free_count_q >= {{(LOG_NUM_REGS-1){1'b0}}, need});
    fire      = ren_ready & (ren0_valid | ren1_valid);
  end

  freelist_lane_steer u_steer (
    .ren0_valid    (ren0_valid),
    .ren0_need     (ren0_need),
    .ren1_valid    (ren1_valid),
    .ren1_need     (ren1_need),
    .fire          (fire),
    .fl_data0      (fl_data0),
    .fl_data1      (fl_data1),
    .need          (need),
    .fl_req0_valid (fl_req0_valid),
    .fl_req1_valid (fl_req1_valid),
    .ren0_pdst     (ren0_pdst),
    .ren1_pdst     (ren1_pdst)
  );

  // Recovery FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CTRL_INIT:     state_d = CTRL_IDLE;
      CTRL_IDLE:     if (rob_state == ROB_STATE_ROLLBACK) state_d = CTRL_ROLLBACK;
      CTRL_ROLLBACK: begin
        if (rob_state == ROB_STATE_WALK)      state_d = CTRL_WALK;
        else if (rob_state == ROB_STATE_IDLE) state_d = CTRL_RESUME;
      end
      CTRL_WALK:     if (rob_state == ROB_STATE_IDLE) state_d = CTRL_RESUME;
      CTRL_RESUME:   state_d = (rob_state == ROB_STATE_ROLLBACK) ? CTRL_ROLLBACK : CTRL_IDLE;
      default:       state_d = CTRL_INIT;
    endcase
  end

  // Credit and in-flight bookkeeping with clamping; any clamp is an error.
  always_comb begin
    nfree  = popcnt2(free0_valid, free1_valid);
    nwalk  = popcnt2(rob_walk0_valid, rob_walk1_valid);
    nalloc = popcnt2(fl_req0_valid, fl_req1_valid);
    sat    = 1'b0;
    if (rob_state == ROB_STATE_ROLLBACK) begin
      fc_i = int'(free_count_q) + int'(inflight_q) + int'(nfree);
      if_i = 0;
    end else if (rob_state == ROB_STATE_WALK) begin
      fc_i = int'(free_count_q) + int'(nfree) - int'(nwalk);
      if_i = int'(inflight_q) + int'(nwalk) - int'(nfree);
    end else begin
      fc_i = int'(free_count_q) + int'(nfree) - int'(nalloc);
      if_i = int'(inflight_q) + int'(nalloc) - int'(nfree);
    end
    if (fc_i > NUM_REGS) begin fc_i = NUM_REGS; sat = 1'b1; end
    if (fc_i < 0)        begin fc_i = 0;        sat = 1'b1; end
    if (if_i > NUM_REGS) begin if_i = NUM_REGS; sat = 1'b1; end
    if (if_i < 0)        begin if_i = 0;        sat = 1'b1; end
    free_count_d = fc_i[LOG_NUM_REGS:0];
    inflight_d   = if_i[LOG_NUM_REGS:0];
  end

  // State and counter registers; reset aborts any recovery in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CTRL_INIT;
      free_count_q <= LOG_NUM_REGS'(0) + (LOG_NUM_REGS+1)'(NUM_REGS);
      inflight_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      free_count_q <= free_count_d;
      inflight_q   <= inflight_d;
    end
  end

  assign free_count = free_count_q;
  assign ctrl_state = state_q;

`ifdef FREELIST_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;
  logic [31:0] perf_alloc_cnt_q, perf_alloc_cnt_d;
  logic        perf_err_q, perf_err_d;

  // Perf counters wrap naturally; the error flag is sticky.
  always_comb begin
    perf_stall_cyc_d = perf_stall_cyc_q;
    if ((ren0_valid | ren1_valid) & ~ren_ready) perf_stall_cyc_d = perf_stall_cyc_q + 32'd1;
    perf_alloc_cnt_d = perf_alloc_cnt_q + {30'd0, nalloc};
    perf_err_d       = perf_err_q | sat;
  end

  // Perf registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cyc_q <= '0;
      perf_alloc_cnt_q <= '0;
      perf_err_q       <= 1'b0;
    end else begin
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_alloc_cnt_q <= perf_alloc_cnt_d;
      perf_err_q       <= perf_err_d;
    end
  end

  assign perf_stall_cyc = perf_stall_cyc_q;
  assign perf_alloc_cnt = perf_alloc_cnt_q;
  assign perf_err       = perf_err_q;
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_freelist_alloc_ctrl.sv
// Directed self-checking bench for freelist_alloc_ctrl.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_freelist_alloc_ctrl;
  import freelist_alloc_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ren0_valid, ren0_need, ren1_valid, ren1_need;
  logic       ren_ready;
  logic [5:0] ren0_pdst, ren1_pdst;
  logic       fl_req0_valid, fl_req1_valid;
  logic [5:0] fl_data0, fl_data1;
  logic       free0_valid, free1_valid;
  logic [1:0] rob_state;
  logic       rob_walk0_valid, rob_walk1_valid;
  logic [5:0] free_count;
  logic [2:0] ctrl_state;
`ifdef FREELIST_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_alloc_cnt;
  logic        perf_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  freelist_alloc_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .ren0_valid      (ren0_valid),
    .ren0_need       (ren0_need),
    .ren1_valid      (ren1_valid),
    .ren1_need       (ren1_need),
    .ren_ready       (ren_ready),
    .ren0_pdst       (ren0_pdst),
    .ren1_pdst       (ren1_pdst),
    .fl_req0_valid   (fl_req0_valid),
    .fl_req1_valid   (fl_req1_valid),
    .fl_data0        (fl_data0),
    .fl_data1        (fl_data1),
    .free0_valid     (free0_valid),
    .free1_valid     (free1_valid),
    .rob_state       (rob_state),
    .rob_walk0_valid (rob_walk0_valid),
    .rob_walk1_valid (rob_walk1_valid),
    .free_count      (free_count),
    .ctrl_state      (ctrl_state)
`ifdef FREELIST_CTRL_PERF_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_alloc_cnt  (perf_alloc_cnt),
    .perf_err        (perf_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_lanes(input logic v0, input logic n0, input logic v1, input logic n1);
    ren0_valid = v0; ren0_need = n0; ren1_valid = v1; ren1_need = n1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_lanes(0, 0, 0, 0);
    fl_data0 = 6'd0; fl_data1 = 6'd0;
    free0_valid = 0; free1_valid = 0;
    rob_state = ROB_STATE_IDLE;
    rob_walk0_valid = 0; rob_walk1_valid = 0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_free_count", 32'(free_count), 32);
    check("rst_state", 32'(ctrl_state), 0);
    check("rst_ready", 32'(ren_ready), 0);

    // 1: reset release, INIT then IDLE
    @(negedge clock);
    reset_n = 1'b1;
    set_lanes(1, 1, 0, 0);
    #1;
    check("init_ready", 32'(ren_ready), 0);
    check("init_req0", 32'(fl_req0_valid), 0);
    check("init_pdst0", 32'(ren0_pdst), 0);
    set_lanes(0, 0, 0, 0);
    tick();
    set_lanes(1, 1, 1, 1);
    #1;
    check("idle_ready", 32'(ren_ready), 1);
    check("idle_free_count", 32'(free_count), 32);
    set_lanes(0, 0, 0, 0);

    // Drain credits to 1: 15 dual allocations plus one single.
    for (int i = 0; i < 15; i++) begin
      set_lanes(1, 1, 1, 1);
      tick();
    end
    set_lanes(1, 1, 0, 0);
    tick();
    set_lanes(0, 0, 0, 0);
    #1;
    check("drain_free_count", 32'(free_count), 1);

    // 2: insufficient credit blocks the whole group; frees are not bypassed
    set_lanes(1, 1, 1, 1);
    #1;
    check("short_ready", 32'(ren_ready), 0);
    check("short_req0", 32'(fl_req0_valid), 0);
    check("short_req1", 32'(fl_req1_valid), 0);
    free0_valid = 1; free1_valid = 1;
    #1;
    check("nobypass_ready", 32'(ren_ready), 0);
    tick();
    free0_valid = 0; free1_valid = 0;
    fl_data0 = 6'd7; fl_data1 = 6'd9;
    #1;
    check("freed_free_count", 32'(free_count), 3);
    check("freed_ready", 32'(ren_ready), 1);
    check("freed_req0", 32'(fl_req0_valid), 1);
    check("freed_req1", 32'(fl_req1_valid), 1);
    check("freed_pdst0", 32'(ren0_pdst), 7);
    check("freed_pdst1", 32'(ren1_pdst), 9);
    tick();
    set_lanes(0, 0, 0, 0);
    #1;
    check("dual_free_count", 32'(free_count), 1);

    // 3: lane1-only request compacts onto port 0
    set_lanes(1, 0, 1, 1);
    fl_data0 = 6'd40; fl_data1 = 6'd13;
    #1;
    check("cmp_ready", 32'(ren_ready), 1);
    check("cmp_req0", 32'(fl_req0_valid), 1);
    check("cmp_req1", 32'(fl_req1_valid), 0);
    check("cmp_pdst1", 32'(ren1_pdst), 40);
    check("cmp_pdst0", 32'(ren0_pdst), 0);
    tick();
    set_lanes(0, 0, 0, 0);
    #1;
    check("cmp_free_count", 32'(free_count), 0);
    set_lanes(0, 0, 1, 1);
    #1;
    check("zero_credit_ready", 32'(ren_ready), 0);
    set_lanes(1, 0, 1, 0);
    #1;
    check("no_need_ready", 32'(ren_ready), 1);
    check("no_need_req0", 32'(fl_req0_valid), 0);
    set_lanes(0, 0, 0, 0);

    // Commit everything back: 16 cycles of dual frees.
    free0_valid = 1; free1_valid = 1;
    for (int i = 0; i < 16; i++) tick();
    free0_valid = 0; free1_valid = 0;
    #1;
    check("commit_free_count", 32'(free_count), 32);

    // 4: allocate 5, then rollback returns them
    set_lanes(1, 1, 1, 1);
    tick();
    tick();
    set_lanes(1, 1, 0, 0);
    tick();
    set_lanes(0, 0, 0, 0);
    #1;
    check("alloc5_free_count", 32'(free_count), 27);
    rob_state = ROB_STATE_ROLLBACK;
    tick();
    set_lanes(1, 1, 1, 1);
    #1;
    check("rb_free_count", 32'(free_count), 32);
    check("rb_state", 32'(ctrl_state), 2);
    check("rb_ready", 32'(ren_ready), 0);
    check("rb_req0", 32'(fl_req0_valid), 0);
    free0_valid = 1;
    tick();
    free0_valid = 0;
    set_lanes(0, 0, 0, 0);
    #1;
    check("rb_sat_free_count", 32'(free_count), 32);
`ifdef FREELIST_CTRL_PERF_EN
    check("perf_err_set", 32'(perf_err), 1);
    check("perf_alloc", perf_alloc_cnt, 39);
`endif

    // 5: walk two cycles with both walk lanes, then resume
    rob_state = ROB_STATE_WALK;
    rob_walk0_valid = 1; rob_walk1_valid = 1;
    tick();
    #1;
    check("walk_state", 32'(ctrl_state), 3);
    check("walk1_free_count", 32'(free_count), 30);
    tick();
    rob_walk0_valid = 0; rob_walk1_valid = 0;
    #1;
    check("walk2_free_count", 32'(free_count), 28);
    rob_state = ROB_STATE_IDLE;
    tick();
    set_lanes(1, 1, 1, 1);
    #1;
    check("resume_state", 32'(ctrl_state), 4);
    check("resume_ready", 32'(ren_ready), 0);
    check("resume_free_count", 32'(free_count), 28);
    tick();
    #1;
    check("post_resume_state", 32'(ctrl_state), 1);
    check("post_resume_ready", 32'(ren_ready), 1);
    tick();
    set_lanes(0, 0, 0, 0);
    #1;
    check("post_resume_free_count", 32'(free_count), 26);

    // 6: reset asserted during WALK aborts to INIT at once
    rob_state = ROB_STATE_ROLLBACK;
    tick();
    #1;
    check("rb2_free_count", 32'(free_count), 32);
    rob_state = ROB_STATE_WALK;
    rob_walk0_valid = 1; rob_walk1_valid = 1;
    tick();
    #1;
    check("walk_b_state", 32'(ctrl_state), 3);
    check("walk_b_free_count", 32'(free_count), 30);
    #2;
    reset_n = 1'b0;
    set_lanes(1, 1, 1, 1);
    #1;
    check("async_rst_state", 32'(ctrl_state), 0);
    check("async_rst_free_count", 32'(free_count), 32);
    check("async_rst_ready", 32'(ren_ready), 0);
    check("async_rst_req0", 32'(fl_req0_valid), 0);
`ifdef FREELIST_CTRL_PERF_EN
    check("async_rst_stall", perf_stall_cyc, 0);
    check("async_rst_alloc", perf_alloc_cnt, 0);
    check("async_rst_err", 32'(perf_err), 0);
`endif
    rob_state = ROB_STATE_IDLE;
    rob_walk0_valid = 0; rob_walk1_valid = 0;
    set_lanes(0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rerelease_state", 32'(ctrl_state), 0);
    tick();
    set_lanes(1, 1, 1, 1);
    #1;
    check("rerelease_ready", 32'(ren_ready), 1);
    set_lanes(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
